// File: rtl/mem_port_arbiter.sv
// Arbitrates one big-endian data memory between the fetch port (I) and the load/store port (D).
// Optional misalignment trapping is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_port_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int PRIO_MODE   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_half,
  input  logic        d_byte,
  input  logic        d_ext,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_ra,
  output logic [31:0] mem_wa,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  output logic        mem_half,
  output logic        mem_byte,
  output logic        mem_ext,
  input  logic [31:0] mem_rd,
  output logic        busy
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          half_q, half_d;
  logic          byte_q, byte_d;
  logic          ext_q, ext_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          grant_d_w;
`ifdef MEM_ALIGN_CHECK_EN
  logic          err_q, err_d;
  logic          mis_w;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      owner_q   <= OWN_I;
      last_q    <= OWN_D;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      half_q    <= 1'b0;
      byte_q    <= 1'b0;
      ext_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      half_q    <= half_d;
      byte_q    <= byte_d;
      ext_q     <= ext_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef MEM_ALIGN_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    half_d    = half_q;
    byte_d    = byte_q;
    ext_d     = ext_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    grant_d_w = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    err_d     = err_q;
    mis_w     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          // On a tie D wins under fixed priority, or when I had the last grant.
          grant_d_w = d_req && (!i_req || (PRIO_MODE == 1) || (last_q == OWN_I));
          owner_d   = grant_d_w;
          last_d    = grant_d_w;
          addr_d    = grant_d_w ? d_addr : i_addr;
          wdata_d   = grant_d_w ? d_wdata : 32'h0;
          we_d      = grant_d_w && d_we;
          half_d    = grant_d_w && d_half;
          byte_d    = grant_d_w && d_byte;
          ext_d     = grant_d_w && d_ext;
          cnt_d     = CW'(WAIT_CYCLES - 1);
          state_d   = ST_WAIT;
`ifdef MEM_ALIGN_CHECK_EN
          if (grant_d_w) begin
            mis_w = d_half ? d_addr[0] : (!d_byte && (d_addr[1:0] != 2'b00));
          end else begin
            mis_w = (i_addr[1:0] != 2'b00);
          end
          err_d = mis_w;
          if (mis_w) begin
            state_d = ST_ACK;
            if (grant_d_w) d_rdata_d = 32'h0;
            else           i_rdata_d = 32'h0;
          end
`endif
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_ACK;
          if (owner_q == OWN_D) d_rdata_d = mem_rd;
          else                  i_rdata_d = mem_rd;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory controls are only live while an access is held in WAIT.
  always_comb begin
    mem_ra   = 32'h0;
    mem_wa   = 32'h0;
    mem_wd   = 32'h0;
    mem_we   = 1'b0;
    mem_half = 1'b0;
    mem_byte = 1'b0;
    mem_ext  = 1'b0;
    if (state_q == ST_WAIT) begin
      mem_ra   = addr_q;
      mem_wa   = addr_q;
      mem_wd   = wdata_q;
      mem_we   = we_q && (cnt_q == '0);
      mem_half = half_q;
      mem_byte = byte_q;
      mem_ext  = ext_q;
    end
  end

  assign i_ack   = (state_q == ST_ACK) && (owner_q == OWN_I);
  assign d_ack   = (state_q == ST_ACK) && (owner_q == OWN_D);
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy    = (state_q != ST_IDLE);
`ifdef MEM_ALIGN_CHECK_EN
  assign d_err   = d_ack && err_q;
`else
  assign d_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a big-endian byte memory model.
// Misalignment cases run only when MEM_ALIGN_CHECK_EN is defined.
module tb_mem_port_arbiter;

  localparam int WAIT_CYCLES = 2;
  localparam int PRIO_MODE   = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_half;
  logic        d_byte;
  logic        d_ext;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] mem_ra;
  logic [31:0] mem_wa;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic        mem_half;
  logic        mem_byte;
  logic        mem_ext;
  logic [31:0] mem_rd;
  logic        busy;

  mem_port_arbiter #(.WAIT_CYCLES(WAIT_CYCLES), .PRIO_MODE(PRIO_MODE)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_half(d_half), .d_byte(d_byte), .d_ext(d_ext),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_ra(mem_ra), .mem_wa(mem_wa), .mem_we(mem_we), .mem_wd(mem_wd),
    .mem_half(mem_half), .mem_byte(mem_byte), .mem_ext(mem_ext),
    .mem_rd(mem_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk;
  } expT;

  expT  iQ[$];
  expT  dQ[$];
  expT  monE;
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  int   weCount = 0;
  int   dAckCount = 0;
  bit   initMem = 1'b1;
  logic [7:0] mem[0:255];
  logic [7:0] shadow[0:255];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] initByte(int a);
    if (a >= 'h10 && a <= 'h13) return 8'(17 * (a - 15));
    return 8'(a ^ 'h5A);
  endfunction

  // Picks the addressed half/byte out of an aligned big-endian word.
  function automatic logic [31:0] shapeRead(logic [31:0] w, logic [1:0] a, logic half, logic isByte, logic ext);
    logic [15:0] h;
    logic [7:0]  b;
    h = a[1] ? w[15:0] : w[31:16];
    case (a)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    if (half)   return ext ? {{16{h[15]}}, h} : {16'h0, h};
    if (isByte) return ext ? {{24{b[7]}}, b} : {24'h0, b};
    return w;
  endfunction

  function automatic logic [31:0] shadowWord(logic [7:0] a);
    return {shadow[{a[7:2], 2'b00}], shadow[{a[7:2], 2'b01}], shadow[{a[7:2], 2'b10}], shadow[{a[7:2], 2'b11}]};
  endfunction

  task automatic shadowStore(logic [7:0] a, logic [31:0] wd, logic half, logic isByte);
    if (half) begin
      shadow[{a[7:1], 1'b0}] = wd[15:8];
      shadow[{a[7:1], 1'b1}] = wd[7:0];
    end else if (isByte) begin
      shadow[a] = wd[7:0];
    end else begin
      shadow[{a[7:2], 2'b00}] = wd[31:24];
      shadow[{a[7:2], 2'b01}] = wd[23:16];
      shadow[{a[7:2], 2'b10}] = wd[15:8];
      shadow[{a[7:2], 2'b11}] = wd[7:0];
    end
  endtask

  function automatic logic isMis(bit port, logic [31:0] a, logic half, logic isByte);
`ifdef MEM_ALIGN_CHECK_EN
    if (!port) return a[1:0] != 2'b00;
    if (half)  return a[0];
    if (isByte) return 1'b0;
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  always_comb begin
    mem_rd = shapeRead({mem[{mem_ra[7:2], 2'b00}], mem[{mem_ra[7:2], 2'b01}],
                        mem[{mem_ra[7:2], 2'b10}], mem[{mem_ra[7:2], 2'b11}]},
                       mem_ra[1:0], mem_half, mem_byte, mem_ext);
  end

  always @(negedge clk) begin
    if (initMem) begin
      for (int a = 0; a < 256; a++) mem[a] <= initByte(a);
    end else if (mem_we) begin
      if (mem_half) begin
        mem[{mem_wa[7:1], 1'b0}] <= mem_wd[15:8];
        mem[{mem_wa[7:1], 1'b1}] <= mem_wd[7:0];
      end else if (mem_byte) begin
        mem[mem_wa[7:0]] <= mem_wd[7:0];
      end else begin
        mem[{mem_wa[7:2], 2'b00}] <= mem_wd[31:24];
        mem[{mem_wa[7:2], 2'b01}] <= mem_wd[23:16];
        mem[{mem_wa[7:2], 2'b10}] <= mem_wd[15:8];
        mem[{mem_wa[7:2], 2'b11}] <= mem_wd[7:0];
      end
    end
  end

  always @(posedge clk) cycle++;

  // Pops the scoreboard whenever either port acknowledges.
  always @(negedge clk) begin
    if (mem_we) weCount++;
    if (i_ack || d_ack) checkOutput("ack_onehot", {31'h0, i_ack & d_ack}, 32'h0);
    if (i_ack) begin
      checkOutput("i_pending", {31'h0, iQ.size() > 0}, 32'h1);
      if (iQ.size() > 0) begin
        monE = iQ.pop_front();
        checkOutput("i_rdata", i_rdata, monE.rdata);
      end
    end
    if (d_ack) begin
      dAckCount++;
      checkOutput("d_pending", {31'h0, dQ.size() > 0}, 32'h1);
      if (dQ.size() > 0) begin
        monE = dQ.pop_front();
        if (monE.chk) checkOutput("d_rdata", d_rdata, monE.rdata);
        checkOutput("d_err", {31'h0, d_err}, {31'h0, monE.err});
      end
    end
  end

  // One full transaction on port I (port=0) or D (port=1); extraDelay covers arbitration losses.
  task automatic applyStimulus(input bit port, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic half, input logic isByte, input logic ext, input int extraDelay,
                               input string tag);
    expT e;
    logic mis;
    int t0, w0, expLat;
    bit got;
    @(negedge clk);
    mis = isMis(port, addr, half, isByte);
    if (!port) begin
      e.rdata = mis ? 32'h0 : shapeRead(shadowWord(addr[7:0]), addr[1:0], 1'b0, 1'b0, 1'b0);
      e.err = 1'b0;
      e.chk = 1'b1;
      iQ.push_back(e);
      i_addr = addr;
      i_req  = 1'b1;
    end else begin
      e.rdata = mis ? 32'h0 : shapeRead(shadowWord(addr[7:0]), addr[1:0], half, isByte, ext);
      e.err = mis;
      e.chk = !we;
      dQ.push_back(e);
      if (we && !mis) shadowStore(addr[7:0], wdata, half, isByte);
      d_we = we; d_addr = addr; d_wdata = wdata; d_half = half; d_byte = isByte; d_ext = ext;
      d_req = 1'b1;
    end
    t0 = cycle;
    w0 = weCount;
    expLat = (mis ? 1 : WAIT_CYCLES + 1) + extraDelay;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (port ? d_ack : i_ack) got = 1'b1;
    end
    checkOutput({tag, "_ack"}, {31'h0, got}, 32'h1);
    checkOutput({tag, "_lat"}, cycle - t0, expLat);
    checkOutput({tag, "_we"}, weCount - w0, (port && we && !mis) ? 1 : 0);
    if (!port) begin
      i_req = 1'b0; i_addr = $urandom;
    end else begin
      d_req = 1'b0; d_addr = $urandom; d_wdata = $urandom; d_we = 1'b1;
    end
  endtask

  initial begin
    int w0, a0;
    logic [31:0] addr;
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_half = 1'b0; d_byte = 1'b0; d_ext = 1'b0;
    for (int a = 0; a < 256; a++) shadow[a] = initByte(a);
    repeat (3) @(negedge clk);
    initMem = 1'b0;
    checkOutput("rst_acks", {29'h0, i_ack, d_ack, d_err}, 32'h0);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_memctl", {28'h0, mem_we, mem_half, mem_byte, mem_ext}, 32'h0);
    checkOutput("rst_mem_ra", mem_ra, 32'h0);
    checkOutput("rst_i_rdata", i_rdata, 32'h0);
    checkOutput("rst_d_rdata", d_rdata, 32'h0);
    rst = 1'b0;

    $display("[TB] tie after reset, fetch first");
    fork
      applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 0, "tie1_i");
      applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0, WAIT_CYCLES + 2, "tie1_d");
    join
    applyStimulus(1'b0, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, 1'b0, 0, "fetch14");
    fork
      applyStimulus(1'b0, 1'b0, 32'h24, 32'h0, 1'b0, 1'b0, 1'b0, WAIT_CYCLES + 2, "tie2_i");
      applyStimulus(1'b1, 1'b0, 32'h28, 32'h0, 1'b0, 1'b0, 1'b0, 0, "tie2_d");
    join

    $display("[TB] byte, half and word stores with reloads");
    applyStimulus(1'b1, 1'b1, 32'h21, 32'h000000A5, 1'b0, 1'b1, 1'b0, 0, "stb21");
    applyStimulus(1'b1, 1'b0, 32'h21, 32'h0, 1'b0, 1'b1, 1'b1, 0, "lbs21");
    applyStimulus(1'b1, 1'b0, 32'h21, 32'h0, 1'b0, 1'b1, 1'b0, 0, "lbu21");
    applyStimulus(1'b1, 1'b1, 32'h30, 32'h00008001, 1'b1, 1'b0, 1'b0, 0, "sth30");
    applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 1'b0, 1'b0, 0, "lhu30");
    applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 1'b0, 1'b1, 0, "lhs30");
    applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 1'b1, 1'b1, 0, "lhb30");
    applyStimulus(1'b1, 1'b1, 32'h34, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 0, "stw34");
    applyStimulus(1'b1, 1'b0, 32'h34, 32'h0, 1'b0, 1'b0, 1'b0, 0, "ldw34");
    applyStimulus(1'b0, 1'b0, 32'h34, 32'h0, 1'b0, 1'b0, 1'b0, 0, "fetch34");

    $display("[TB] random load/store mix");
    for (int k = 0; k < 10; k++) begin
      addr = 32'h80 + $urandom_range(0, 127);
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), addr, $urandom, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, "rnd");
    end

    $display("[TB] reset during a store");
    applyStimulus(1'b0, 1'b0, 32'h18, 32'h0, 1'b0, 1'b0, 1'b0, 0, "fetch18");
    @(negedge clk);
    w0 = weCount; a0 = dAckCount;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678; d_half = 1'b0; d_byte = 1'b0; d_ext = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_busy_wait", {31'h0, busy}, 32'h1);
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_mid_we", {31'h0, mem_we}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("rst_mid_mem40", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, shadowWord(8'h40));
    checkOutput("rst_mid_wecount", weCount - w0, 32'h0);
    checkOutput("rst_mid_noack", dAckCount - a0, 32'h0);
    fork
      applyStimulus(1'b0, 1'b0, 32'h1C, 32'h0, 1'b0, 1'b0, 1'b0, 0, "tie3_i");
      applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, WAIT_CYCLES + 2, "tie3_d");
    join

`ifdef MEM_ALIGN_CHECK_EN
    $display("[TB] misaligned accesses");
    applyStimulus(1'b1, 1'b0, 32'h42, 32'h0, 1'b0, 1'b0, 1'b0, 0, "mis_lw42");
    applyStimulus(1'b1, 1'b1, 32'h46, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 0, "mis_sw46");
    applyStimulus(1'b1, 1'b0, 32'h43, 32'h0, 1'b1, 1'b0, 1'b1, 0, "mis_lh43");
    applyStimulus(1'b0, 1'b0, 32'h11, 32'h0, 1'b0, 1'b0, 1'b0, 0, "mis_fetch11");
    applyStimulus(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0, 1'b0, 0, "ldw44");
`endif

    repeat (3) @(negedge clk);
    checkOutput("sb_i_empty", iQ.size(), 32'h0);
    checkOutput("sb_d_empty", dQ.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
